// File: rtl/bp_pkg.sv
// Shared types and constants for the polar BP decoder scheduler and its PE array.
package bp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        CHECK,
        DONE
    } bp_state_t;

    typedef enum logic {
        DIR_R = 1'b0,
        DIR_L = 1'b1
    } bp_dir_t;

    // [1][7][12] LLR format used by the f/g min-sum PEs
    localparam int LLR_W    = 20;
    localparam int LLR_INT  = 7;
    localparam int LLR_FRAC = 12;

    function automatic int stage_w(input int log_n);
        return (log_n > 1) ? $clog2(log_n) : 1;
    endfunction

    function automatic int group_w(input int log_n, input int log_p);
        return (log_n - 1 - log_p > 1) ? (log_n - 1 - log_p) : 1;
    endfunction

endpackage

// File: rtl/bp_tag_delay.sv
// Fixed-depth shift register that turns issue tags into write-back tags.
module bp_tag_delay #(
    parameter int DEPTH = 2,
    parameter int W     = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] pipe [DEPTH];

    // NOTE: the delay line is cleared on reset, unlike a data RAM, so no
    // write-back issued before reset can surface afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/bp_sched.sv
// BP decoder PE-array sequencer: L then R sweep per iteration, drain bubbles,
// iteration cap. Define BP_EARLY_STOP_EN to add the convergence-check handshake.
module bp_sched
    import bp_pkg::*;
#(
    parameter int LOG_N  = 10,
    parameter int LOG_P  = 4,
    parameter int PE_LAT = 2,
    parameter int ITER_W = 6
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [ITER_W-1:0]                  max_iter,
    output logic                               busy,
    output logic                               done,
    output logic [ITER_W-1:0]                  iter_cnt,
    output logic                               pe_en,
    output logic                               pe_dir,
    output logic [stage_w(LOG_N)-1:0]          pe_stage,
    output logic [group_w(LOG_N, LOG_P)-1:0]   pe_group,
    output logic                               wb_en,
    output logic                               wb_dir,
    output logic [stage_w(LOG_N)-1:0]          wb_stage,
    output logic [group_w(LOG_N, LOG_P)-1:0]   wb_group
`ifdef BP_EARLY_STOP_EN
    ,
    output logic                               chk_req,
    input  logic                               chk_valid,
    input  logic                               converged
`endif
);

    localparam int SW = stage_w(LOG_N);
    localparam int GW = group_w(LOG_N, LOG_P);
    localparam int G  = 1 << (LOG_N - 1 - LOG_P);
    localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
    localparam int TW = 2 + SW + GW;

    localparam logic [SW-1:0] LAST_STAGE = SW'(LOG_N - 1);
    localparam logic [GW-1:0] LAST_GROUP = GW'(G - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(PE_LAT - 1);

    bp_state_t         state;
    logic [ITER_W-1:0] cap_q;
    logic [DW-1:0]     drain_cnt;
    logic [ITER_W-1:0] iter_next;

    assign iter_next = iter_cnt + ITER_W'(1);

    // NOTE: every register below is state, so all assignments are non-blocking;
    // outputs are registered and reflect the cycle they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            iter_cnt  <= '0;
            cap_q     <= '0;
            drain_cnt <= '0;
            pe_en     <= 1'b0;
            pe_dir    <= DIR_R;
            pe_stage  <= '0;
            pe_group  <= '0;
`ifdef BP_EARLY_STOP_EN
            chk_req   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef BP_EARLY_STOP_EN
            chk_req <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ISSUE;
                        busy     <= 1'b1;
                        cap_q    <= (max_iter == '0) ? ITER_W'(1) : max_iter;
                        iter_cnt <= '0;
                        pe_en    <= 1'b1;
                        pe_dir   <= DIR_L;
                        pe_stage <= LAST_STAGE;
                        pe_group <= '0;
                    end
                end
                ISSUE: begin
                    if (pe_group == LAST_GROUP) begin
                        state     <= DRAIN;
                        pe_en     <= 1'b0;
                        drain_cnt <= '0;
                    end else begin
                        pe_group <= pe_group + GW'(1);
                    end
                end
                DRAIN: begin
                    if (drain_cnt != LAST_DRAIN) begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end else if (pe_dir == DIR_L) begin
                        // L sweep turns around at stage 0 into the R sweep
                        state    <= ISSUE;
                        pe_en    <= 1'b1;
                        pe_group <= '0;
                        if (pe_stage == '0) pe_dir <= DIR_R;
                        else                pe_stage <= pe_stage - SW'(1);
                    end else if (pe_stage != LAST_STAGE) begin
                        state    <= ISSUE;
                        pe_en    <= 1'b1;
                        pe_group <= '0;
                        pe_stage <= pe_stage + SW'(1);
                    end else begin
                        iter_cnt <= iter_next;
                        if (iter_next == cap_q) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
`ifdef BP_EARLY_STOP_EN
                            state   <= CHECK;
                            chk_req <= 1'b1;
`else
                            state    <= ISSUE;
                            pe_en    <= 1'b1;
                            pe_dir   <= DIR_L;
                            pe_stage <= LAST_STAGE;
                            pe_group <= '0;
`endif
                        end
                    end
                end
`ifdef BP_EARLY_STOP_EN
                CHECK: begin
                    if (chk_valid) begin
                        if (converged) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state    <= ISSUE;
                            pe_en    <= 1'b1;
                            pe_dir   <= DIR_L;
                            pe_stage <= LAST_STAGE;
                            pe_group <= '0;
                        end
                    end
                end
`endif
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    logic [TW-1:0] wb_tag;

    bp_tag_delay #(
        .DEPTH (PE_LAT),
        .W     (TW)
    ) u_tag_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({pe_en, pe_dir, pe_stage, pe_group}),
        .dout (wb_tag)
    );

    assign {wb_en, wb_dir, wb_stage, wb_group} = wb_tag;

endmodule
